// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the RAM_B port arbiter and its requesters / RAM.
// slave = arbiter side, master = requesters plus the RAM itself.
interface ram_port_arbiter_if #(
  parameter int AW        = 10,
  parameter int DW        = 32,
  parameter int PS2_DEPTH = 4
);
  localparam int LW = $clog2(PS2_DEPTH) + 1;

  // Handshakes: cpu_req/disp_req are held until the matching *_gnt is seen in
  // the same cycle; a read returns on rdata with *_rvalid exactly one cycle
  // after its grant. ps2_valid/ps2_ready transfer a write when both are high.
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_gnt;
  logic          disp_rvalid;
  logic [DW-1:0] rdata;
  logic          ps2_valid;
  logic [AW-1:0] ps2_addr;
  logic [DW-1:0] ps2_data;
  logic          ps2_ready;
  logic          ps2_ovf;
  logic          ovf_clr;
  logic [LW-1:0] fifo_level;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic [15:0]   perf_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, disp_req, disp_addr,
           ps2_valid, ps2_addr, ps2_data, ovf_clr, ram_dout,
    output cpu_gnt, cpu_rvalid, disp_gnt, disp_rvalid, rdata, ps2_ready,
           ps2_ovf, fifo_level, ram_addr, ram_we, ram_din, perf_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, disp_req, disp_addr,
           ps2_valid, ps2_addr, ps2_data, ovf_clr, ram_dout,
    input  cpu_gnt, cpu_rvalid, disp_gnt, disp_rvalid, rdata, ps2_ready,
           ps2_ovf, fifo_level, ram_addr, ram_we, ram_din, perf_cnt
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Single-port RAM_B arbiter: CPU > display > PS2 FIFO, with an aging override
// for the FIFO head. Optional display-denial counter under ARB_PERF_EN.
module ram_port_arbiter #(
  parameter int AW        = 10,
  parameter int DW        = 32,
  parameter int PS2_DEPTH = 4,
  parameter int MAX_WAIT  = 15
) (
  input logic               clk,
  input logic               RSTN,
  ram_port_arbiter_if.slave bus
);
  localparam int PW  = $clog2(PS2_DEPTH);
  localparam int LW  = PW + 1;
  localparam int AGW = $clog2(MAX_WAIT + 1);

  logic [AW-1:0]  fifo_addr [PS2_DEPTH];
  logic [DW-1:0]  fifo_data [PS2_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]  level;
  logic [AGW-1:0] age;
  logic           ovf_q, cpu_rvalid_q, disp_rvalid_q;
  logic [AW-1:0]  addr_q;

  logic fifo_nempty, forced, push, pop, fifo_gnt, cpu_gnt, disp_gnt;

  assign fifo_nempty   = (level != '0);
  assign forced        = fifo_nempty && (age == AGW'(MAX_WAIT));
  assign bus.ps2_ready = (level != LW'(PS2_DEPTH));
  assign push          = bus.ps2_valid && bus.ps2_ready;
  assign pop           = fifo_gnt;

  // Grants are gated by RSTN so nothing reaches the RAM while in reset.
  always_comb begin
    cpu_gnt  = 1'b0;
    disp_gnt = 1'b0;
    fifo_gnt = 1'b0;
    if (RSTN) begin
      if (forced)            fifo_gnt = 1'b1;
      else if (bus.cpu_req)  cpu_gnt  = 1'b1;
      else if (bus.disp_req) disp_gnt = 1'b1;
      else if (fifo_nempty)  fifo_gnt = 1'b1;
    end
  end

  always_comb begin
    bus.ram_addr = addr_q;
    bus.ram_we   = 1'b0;
    bus.ram_din  = '0;
    if (cpu_gnt) begin
      bus.ram_addr = bus.cpu_addr;
      bus.ram_we   = bus.cpu_we;
      bus.ram_din  = bus.cpu_wdata;
    end else if (disp_gnt) begin
      bus.ram_addr = bus.disp_addr;
    end else if (fifo_gnt) begin
      bus.ram_addr = fifo_addr[rd_ptr];
      bus.ram_we   = 1'b1;
      bus.ram_din  = fifo_data[rd_ptr];
    end
  end

  assign bus.cpu_gnt     = cpu_gnt;
  assign bus.disp_gnt    = disp_gnt;
  assign bus.cpu_rvalid  = cpu_rvalid_q;
  assign bus.disp_rvalid = disp_rvalid_q;
  assign bus.rdata       = bus.ram_dout;
  assign bus.ps2_ovf     = ovf_q;
  assign bus.fifo_level  = level;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.ps2_addr;
      fifo_data[wr_ptr] <= bus.ps2_data;
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      age           <= '0;
      ovf_q         <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      disp_rvalid_q <= 1'b0;
      addr_q        <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;

      if (!fifo_nempty || pop)        age <= '0;
      else if (age != AGW'(MAX_WAIT)) age <= age + 1'b1;

      // A new overflow beats a clear in the same cycle.
      if (bus.ps2_valid && !bus.ps2_ready) ovf_q <= 1'b1;
      else if (bus.ovf_clr)                ovf_q <= 1'b0;

      cpu_rvalid_q  <= cpu_gnt && !bus.cpu_we;
      disp_rvalid_q <= disp_gnt;
      addr_q        <= bus.ram_addr;
    end
  end

`ifdef ARB_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN)                                            perf_q <= '0;
    else if (bus.ovf_clr)                                 perf_q <= '0;
    else if (bus.disp_req && !disp_gnt && perf_q != 16'hFFFF) perf_q <= perf_q + 16'd1;
  end

  assign bus.perf_cnt = perf_q;
`else
  assign bus.perf_cnt = '0;
`endif
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 1-cycle-latency RAM.
module tb_ram_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

`ifdef ARB_PERF_EN
  localparam logic [15:0] PERF_AFTER_BLOCK = 16'd3;
`else
  localparam logic [15:0] PERF_AFTER_BLOCK = 16'd0;
`endif

  logic clk;
  logic rstn;
  int   n_vec;
  int   n_err;

  ram_port_arbiter_if #(.AW(AW), .DW(DW), .PS2_DEPTH(4)) bus ();

  ram_port_arbiter #(.AW(AW), .DW(DW), .PS2_DEPTH(4), .MAX_WAIT(15)) dut (
    .clk  (clk),
    .RSTN (rstn),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] ram_mem [1024];
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= ram_mem[bus.ram_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 2 units later.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.disp_req  = 1'b0;
    bus.disp_addr = '0;
    bus.ps2_valid = 1'b0;
    bus.ps2_addr  = '0;
    bus.ps2_data  = '0;
    bus.ovf_clr   = 1'b0;
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  task automatic ps2_drive(input logic v, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.ps2_valid = v;
    bus.ps2_addr  = addr;
    bus.ps2_data  = data;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn  = 1'b0;
    clear_inputs();

    // reset state
    #2;
    bus.cpu_req = 1'b1;
    #1;
    check("rst_cpu_gnt", 64'(bus.cpu_gnt), 64'd0);
    check("rst_ram_we", 64'(bus.ram_we), 64'd0);
    check("rst_level", 64'(bus.fifo_level), 64'd0);
    check("rst_ready", 64'(bus.ps2_ready), 64'd1);
    check("rst_ovf", 64'(bus.ps2_ovf), 64'd0);
    check("rst_rvalid", 64'({bus.cpu_rvalid, bus.disp_rvalid}), 64'd0);
    check("rst_perf", 64'(bus.perf_cnt), 64'd0);
    bus.cpu_req = 1'b0;
    next();
    next();
    rstn = 1'b1;

    // CPU write then read of 0x005
    next();
    cpu_drive(1'b1, 1'b1, 10'h005, 32'h0000_0800);
    settle();
    check("wr_gnt", 64'(bus.cpu_gnt), 64'd1);
    check("wr_ram_we", 64'(bus.ram_we), 64'd1);
    check("wr_ram_addr", 64'(bus.ram_addr), 64'h005);
    check("wr_ram_din", 64'(bus.ram_din), 64'h800);
    next();
    cpu_drive(1'b1, 1'b0, 10'h005, '0);
    settle();
    check("rd_gnt", 64'(bus.cpu_gnt), 64'd1);
    check("rd_ram_we", 64'(bus.ram_we), 64'd0);
    check("wr_no_rvalid", 64'(bus.cpu_rvalid), 64'd0);
    next();
    cpu_drive(1'b0, 1'b0, '0, '0);
    settle();
    check("rd_rvalid", 64'(bus.cpu_rvalid), 64'd1);
    check("rd_rdata", 64'(bus.rdata), 64'h800);
    check("idle_addr_hold", 64'(bus.ram_addr), 64'h005);
    check("idle_ram_we", 64'(bus.ram_we), 64'd0);

    // CPU blocks display for 3 cycles
    next();
    cpu_drive(1'b1, 1'b1, 10'h002, 32'h1234_5678);
    settle();
    for (int i = 0; i < 3; i++) begin
      next();
      cpu_drive(1'b1, 1'b0, 10'h001, '0);
      bus.disp_req  = 1'b1;
      bus.disp_addr = 10'h002;
      settle();
      check("blk_cpu_gnt", 64'(bus.cpu_gnt), 64'd1);
      check("blk_disp_gnt", 64'(bus.disp_gnt), 64'd0);
    end
    next();
    cpu_drive(1'b0, 1'b0, '0, '0);
    settle();
    check("blk_perf", 64'(bus.perf_cnt), 64'(PERF_AFTER_BLOCK));
    check("disp_gnt", 64'(bus.disp_gnt), 64'd1);
    check("disp_ram_addr", 64'(bus.ram_addr), 64'h002);
    next();
    bus.disp_req = 1'b0;
    settle();
    check("disp_rvalid", 64'(bus.disp_rvalid), 64'd1);
    check("disp_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd0);
    check("disp_rdata", 64'(bus.rdata), 64'h1234_5678);

    // PS2 burst of 5 while CPU holds the port
    for (int i = 0; i < 5; i++) begin
      next();
      cpu_drive(1'b1, 1'b0, 10'h000, '0);
      ps2_drive(1'b1, 10'(10'h100 + i), 32'(32'hA0 + i));
      settle();
      check("burst_ready", 64'(bus.ps2_ready), 64'(i < 4));
      check("burst_level", 64'(bus.fifo_level), 64'(i));
    end
    next();
    ps2_drive(1'b0, '0, '0);
    settle();
    check("burst_ovf", 64'(bus.ps2_ovf), 64'd1);
    check("burst_full", 64'(bus.fifo_level), 64'd4);
    check("burst_not_ready", 64'(bus.ps2_ready), 64'd0);
    check("burst_cpu_gnt", 64'(bus.cpu_gnt), 64'd1);
    next();
    bus.ovf_clr = 1'b1;
    settle();
    check("clr_ovf_held", 64'(bus.ps2_ovf), 64'd1);
    next();
    bus.ovf_clr = 1'b0;
    cpu_drive(1'b0, 1'b0, '0, '0);
    settle();
    check("clr_ovf", 64'(bus.ps2_ovf), 64'd0);
    check("clr_perf", 64'(bus.perf_cnt), 64'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        next();
        settle();
      end
      check("drain_we", 64'(bus.ram_we), 64'd1);
      check("drain_addr", 64'(bus.ram_addr), 64'(10'h100 + i));
      check("drain_din", 64'(bus.ram_din), 64'(32'hA0 + i));
    end
    next();
    settle();
    check("drain_empty", 64'(bus.fifo_level), 64'd0);

    // aging: one entry starved by continuous CPU reads
    next();
    cpu_drive(1'b1, 1'b0, 10'h000, '0);
    ps2_drive(1'b1, 10'h3F0, 32'h0000_BEEF);
    settle();
    for (int k = 1; k <= 16; k++) begin
      next();
      ps2_drive(1'b0, '0, '0);
      settle();
      check("age_cpu_gnt", 64'(bus.cpu_gnt), 64'(k != 16));
      if (k == 16) begin
        check("age_forced_we", 64'(bus.ram_we), 64'd1);
        check("age_forced_addr", 64'(bus.ram_addr), 64'h3F0);
        check("age_forced_din", 64'(bus.ram_din), 64'h0000_BEEF);
      end
    end
    next();
    settle();
    check("age_level", 64'(bus.fifo_level), 64'd0);
    check("age_cpu_back", 64'(bus.cpu_gnt), 64'd1);

    // push and pop together at level 2
    next();
    ps2_drive(1'b1, 10'h010, 32'hC0);
    next();
    ps2_drive(1'b1, 10'h011, 32'hC1);
    next();
    cpu_drive(1'b0, 1'b0, '0, '0);
    ps2_drive(1'b1, 10'h012, 32'hC2);
    settle();
    check("pp_level_before", 64'(bus.fifo_level), 64'd2);
    check("pp_addr0", 64'(bus.ram_addr), 64'h010);
    check("pp_din0", 64'(bus.ram_din), 64'hC0);
    next();
    ps2_drive(1'b0, '0, '0);
    settle();
    check("pp_level_after", 64'(bus.fifo_level), 64'd2);
    check("pp_addr1", 64'(bus.ram_addr), 64'h011);
    check("pp_din1", 64'(bus.ram_din), 64'hC1);
    next();
    settle();
    check("pp_addr2", 64'(bus.ram_addr), 64'h012);
    check("pp_din2", 64'(bus.ram_din), 64'hC2);
    next();
    cpu_drive(1'b1, 1'b0, 10'h012, '0);
    settle();
    check("pp_empty", 64'(bus.fifo_level), 64'd0);
    next();
    cpu_drive(1'b0, 1'b0, '0, '0);
    settle();
    check("pp_readback", 64'(bus.rdata), 64'hC2);

    // reset in the cycle after a display grant
    for (int i = 0; i < 5; i++) begin
      next();
      bus.disp_req  = 1'b1;
      bus.disp_addr = 10'h002;
      ps2_drive(1'b1, 10'(10'h020 + i), 32'(i));
      settle();
      check("pre_rst_disp_gnt", 64'(bus.disp_gnt), 64'd1);
    end
    next();
    ps2_drive(1'b0, '0, '0);
    settle();
    check("pre_rst_level", 64'(bus.fifo_level), 64'd4);
    check("pre_rst_ovf", 64'(bus.ps2_ovf), 64'd1);
    next();
    rstn = 1'b0;
    settle();
    check("mid_rst_disp_rvalid", 64'(bus.disp_rvalid), 64'd0);
    check("mid_rst_disp_gnt", 64'(bus.disp_gnt), 64'd0);
    check("mid_rst_level", 64'(bus.fifo_level), 64'd0);
    check("mid_rst_ovf", 64'(bus.ps2_ovf), 64'd0);
    check("mid_rst_ready", 64'(bus.ps2_ready), 64'd1);
    check("mid_rst_ram_we", 64'(bus.ram_we), 64'd0);
    next();
    clear_inputs();
    rstn = 1'b1;
    next();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
